pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128: payload width in bits (rd/uop/mem/csr/exception/inst fields, packed).
REQ-002 SHALL have parameter DEPTH, default 2: buffer entries; power of two, >=2.
REQ-003 SHALL have parameter PC_W, default 32: PC width in bits.
REQ-004 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port flush_i, input, 1: synchronous pipeline flush.
REQ-007 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): upstream handshake.
REQ-008 SHALL have ports in_data_i (input, DATA_W) and in_pc_i (input, PC_W): upstream payload and PC.
REQ-009 SHALL have ports in_branch_tag_i (input, 1) and in_slot_end_i (input, 1): branch start flag and branch-slot end flag.
REQ-010 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1): downstream handshake.
REQ-011 SHALL have ports out_data_o (output, DATA_W) and out_pc_o (output, PC_W): head-entry payload and PC.
REQ-012 SHALL have port count_o, output, $clog2(DEPTH+1): current occupancy.

Function
REQ-013 SHALL push on any rising edge where in_valid_i && in_ready_o && !flush_i, and pop on any rising edge where out_valid_o && out_ready_i && !flush_i.
REQ-014 SHALL drive in_ready_o = (count != DEPTH) and out_valid_o = (count != 0), decoded from registered state only, with no combinational path from out_ready_i or in_valid_i.
REQ-015 SHALL present a pushed entry on out_* exactly one cycle after the push edge (latency 1), in FIFO order.
REQ-016 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-017 SHALL wrap read and write pointers from DEPTH-1 to 0.
REQ-018 SHALL, when full, hold in_ready_o low even when out_ready_i is high; a push becomes possible only on the cycle after a pop.
REQ-019 SHALL drive out_data_o and out_pc_o to all-zero whenever out_valid_o is low.
REQ-020 SHALL, on flush_i high at an edge, zero count and both pointers, clear branch state, and ignore any push or pop that coincides with it; storage contents need not be cleared.
REQ-021 SHALL, without the configuration macro, store in_pc_i unchanged as the entry PC.

Reset
REQ-022 SHALL, while rst_i is high, immediately force count=0, pointers=0, branch_active=0 and branch_pc=0, giving in_ready_o=1, out_valid_o=0, out_data_o=0, out_pc_o=0 and count_o=0.
REQ-023 SHALL discard all entries when rst_i is asserted mid-transfer and accept a push on the first edge after release.

Configuration
REQ-024 SHALL compile the branch-PC hold logic only when macro PIPE_BRANCH_PC_EN is defined.
REQ-025 SHALL, with PIPE_BRANCH_PC_EN defined, store as entry PC the pre-update branch_pc if branch_active is set at the push edge, and in_pc_i otherwise.
REQ-026 SHALL, with PIPE_BRANCH_PC_EN defined, on each push: if in_branch_tag_i, set branch_active=1 and branch_pc=in_pc_i (takes priority even when in_slot_end_i is also high); else if branch_active && in_slot_end_i, clear branch_active.
REQ-027 SHALL, without PIPE_BRANCH_PC_EN, ignore in_branch_tag_i and in_slot_end_i and contain no branch registers.

Verification
REQ-028 SHALL be verified by: DEPTH=2, out_ready_i=0, push A, B then offer C -> in_ready_o=0 after B, count_o=2; raise out_ready_i -> A pops, C is accepted one cycle later; order A,B,C.
REQ-029 SHALL be verified by: continuous valid/ready at DEPTH=4, 100 entries -> one transfer per cycle, count_o held at 1, no loss or reordering across pointer wrap.
REQ-030 SHALL be verified by: count=3, flush_i pulsed with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, out_data_o=0, and the coincident entry is dropped.
REQ-031 SHALL be verified by: PIPE_BRANCH_PC_EN defined, pushes pc 0x100 (tag), 0x104, 0x108 (slot_end), 0x10C -> out_pc 0x100, 0x100, 0x100, 0x10C.
REQ-032 SHALL be verified by: PIPE_BRANCH_PC_EN defined, tag and slot_end both high on every push at pc 0x200 -> every entry after the first shows 0x200 and branch_active stays 1; with the macro undefined the same stimulus shows in_pc_i.
REQ-033 SHALL be verified by: rst_i pulsed asynchronously between clock edges while count=2 -> outputs reach their reset values without waiting for a clock edge, and a push on the first edge after release is accepted.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Registered FIFO stage between pipeline stages; branch-slot PC hold compiled in by `PIPE_BRANCH_PC_EN.
// Latency: 1 cycle from push edge to out_*; simultaneous push/pop sustains one transfer per cycle.
// Backpressure: in_ready_o/out_valid_o decode registered occupancy only; a full buffer reopens the cycle after a pop.
module pipe_skid_reg #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2,
    parameter int PC_W   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    input  logic [PC_W-1:0]            in_pc_i,
    input  logic                       in_branch_tag_i,
    input  logic                       in_slot_end_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [PC_W-1:0]            out_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic              push;
    logic              pop;
    logic [PC_W-1:0]   entry_pc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready_o  = (count_q != CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (flush_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage is left uncleared on reset/flush; outputs are masked by out_valid_o instead.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= in_data_i;
            pc_mem[wr_ptr_q]   <= entry_pc;
        end
    end

`ifdef PIPE_BRANCH_PC_EN
    logic            branch_active_q;
    logic [PC_W-1:0] branch_pc_q;

    // Entries inside a branch slot inherit the PC of the branch that opened it.
    assign entry_pc = branch_active_q ? branch_pc_q : in_pc_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_active_q <= 1'b0;
            branch_pc_q     <= '0;
        end else if (flush_i) begin
            branch_active_q <= 1'b0;
            branch_pc_q     <= '0;
        end else if (push) begin
            if (in_branch_tag_i) begin
                branch_active_q <= 1'b1;
                branch_pc_q     <= in_pc_i;
            end else if (branch_active_q && in_slot_end_i) begin
                branch_active_q <= 1'b0;
            end
        end
    end
`else
    logic unused_branch_inputs;

    assign unused_branch_inputs = in_branch_tag_i ^ in_slot_end_i;
    assign entry_pc             = in_pc_i;
`endif

    assign out_data_o = out_valid_o ? data_mem[rd_ptr_q] : '0;
    assign out_pc_o   = out_valid_o ? pc_mem[rd_ptr_q]   : '0;
    assign count_o    = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: DEPTH=2 and DEPTH=4 instances share stimulus and are checked against a queue model.
module tb_pipe_skid_reg;
    localparam int DW = 32;
    localparam int PW = 32;

    logic          clk_i           = 1'b0;
    logic          rst_i           = 1'b0;
    logic          flush_i         = 1'b0;
    logic          in_valid_i      = 1'b0;
    logic          in_branch_tag_i = 1'b0;
    logic          in_slot_end_i   = 1'b0;
    logic          out_ready_i     = 1'b0;
    logic [DW-1:0] in_data_i       = '0;
    logic [PW-1:0] in_pc_i         = '0;

    logic          rdy2, vld2, rdy4, vld4;
    logic [DW-1:0] dat2, dat4;
    logic [PW-1:0] pc2, pc4;
    logic [1:0]    cnt2;
    logic [2:0]    cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pipe_skid_reg #(.DATA_W(DW), .DEPTH(2), .PC_W(PW)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(rdy2), .in_data_i(in_data_i), .in_pc_i(in_pc_i),
        .in_branch_tag_i(in_branch_tag_i), .in_slot_end_i(in_slot_end_i),
        .out_valid_o(vld2), .out_ready_i(out_ready_i), .out_data_o(dat2), .out_pc_o(pc2),
        .count_o(cnt2)
    );

    pipe_skid_reg #(.DATA_W(DW), .DEPTH(4), .PC_W(PW)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(rdy4), .in_data_i(in_data_i), .in_pc_i(in_pc_i),
        .in_branch_tag_i(in_branch_tag_i), .in_slot_end_i(in_slot_end_i),
        .out_valid_o(vld4), .out_ready_i(out_ready_i), .out_data_o(dat4), .out_pc_o(pc4),
        .count_o(cnt4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue per instance, branch-slot PC tracked per instance.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [PW-1:0] pc;
    } ent_t;

    ent_t q2[$];
    ent_t q4[$];
    bit   psh2, pop2, psh4, pop4;
`ifdef PIPE_BRANCH_PC_EN
    bit            ba2 = 1'b0;
    bit            ba4 = 1'b0;
    logic [PW-1:0] bp2 = '0;
    logic [PW-1:0] bp4 = '0;
`endif

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            q2.delete();
            q4.delete();
`ifdef PIPE_BRANCH_PC_EN
            ba2 = 1'b0; ba4 = 1'b0; bp2 = '0; bp4 = '0;
`endif
        end else begin
            psh2 = in_valid_i && (q2.size() < 2);
            pop2 = out_ready_i && (q2.size() > 0);
            psh4 = in_valid_i && (q4.size() < 4);
            pop4 = out_ready_i && (q4.size() > 0);
            if (pop2) void'(q2.pop_front());
            if (pop4) void'(q4.pop_front());
`ifdef PIPE_BRANCH_PC_EN
            if (psh2) begin
                q2.push_back('{d: in_data_i, pc: (ba2 ? bp2 : in_pc_i)});
                if (in_branch_tag_i) begin ba2 = 1'b1; bp2 = in_pc_i; end
                else if (in_slot_end_i) ba2 = 1'b0;
            end
            if (psh4) begin
                q4.push_back('{d: in_data_i, pc: (ba4 ? bp4 : in_pc_i)});
                if (in_branch_tag_i) begin ba4 = 1'b1; bp4 = in_pc_i; end
                else if (in_slot_end_i) ba4 = 1'b0;
            end
`else
            if (psh2) q2.push_back('{d: in_data_i, pc: in_pc_i});
            if (psh4) q4.push_back('{d: in_data_i, pc: in_pc_i});
`endif
        end
    end

    always @(negedge clk_i) begin
        ent_t h2, h4;
        h2 = '0;
        h4 = '0;
        if (q2.size() > 0) h2 = q2[0];
        if (q4.size() > 0) h4 = q4[0];
        chk("m_vld2", vld2, q2.size() > 0);
        chk("m_rdy2", rdy2, q2.size() < 2);
        chk("m_cnt2", cnt2, q2.size());
        chk("m_dat2", dat2, h2.d);
        chk("m_pc2",  pc2,  h2.pc);
        chk("m_vld4", vld4, q4.size() > 0);
        chk("m_rdy4", rdy4, q4.size() < 4);
        chk("m_cnt4", cnt4, q4.size());
        chk("m_dat4", dat4, h4.d);
        chk("m_pc4",  pc4,  h4.pc);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [PW-1:0] pc,
                         input logic tag, input logic se);
        in_valid_i      = v;
        in_data_i       = d;
        in_pc_i         = pc;
        in_branch_tag_i = tag;
        in_slot_end_i   = se;
    endtask

    initial begin
        logic [PW-1:0] exp31 [4];

        #1 rst_i = 1'b1;
        #2;
        chk("rst_rdy", rdy2, 1'b1);
        chk("rst_vld", vld2, 1'b0);
        chk("rst_cnt", cnt2, 2'd0);
        chk("rst_dat", dat2, 32'h0);
        chk("rst_pc",  pc2,  32'h0);
        chk("rst_cnt4", cnt4, 3'd0);
        #9 rst_i = 1'b0;

        // Fill DEPTH=2, offer C while full, then release downstream.
        drive(1'b1, 32'hA, 32'h10, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hB, 32'h14, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hC, 32'h18, 1'b0, 1'b0);
        #3;
        chk("full_rdy", rdy2, 1'b0);
        chk("full_cnt", cnt2, 2'd2);
        chk("full_head", dat2, 32'hA);
        step();
        #3;
        chk("full_hold_cnt", cnt2, 2'd2);
        out_ready_i = 1'b1;
        #1;
        chk("full_rdy_orhi", rdy2, 1'b0);
        step();
        #3;
        chk("pop_a_cnt", cnt2, 2'd1);
        chk("pop_a_head", dat2, 32'hB);
        chk("pop_a_rdy", rdy2, 1'b1);
        step();
        #3;
        chk("c_acc_cnt", cnt2, 2'd1);
        chk("c_acc_head", dat2, 32'hC);
        in_valid_i = 1'b0;
        step();
        #3;
        chk("drain_cnt", cnt2, 2'd0);
        chk("drain_dat", dat2, 32'h0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // Streaming through DEPTH=4 across many pointer wraps.
        out_ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, DW'(1000 + i), PW'(i * 4), 1'b0, 1'b0);
            step();
            #3;
            chk("stream_cnt", cnt4, 3'd1);
            chk("stream_head", dat4, DW'(1000 + i));
        end
        in_valid_i = 1'b0;
        step();
        #3;
        chk("stream_end", cnt4, 3'd0);

        // Flush with occupancy 3 and a coincident push.
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(32'h500 + i), PW'(32'h50 + i), 1'b0, 1'b0);
            step();
        end
        #3;
        chk("pre_flush_cnt", cnt4, 3'd3);
        drive(1'b1, 32'hDEAD, 32'h60, 1'b0, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        #3;
        chk("flush_cnt", cnt4, 3'd0);
        chk("flush_vld", vld4, 1'b0);
        chk("flush_dat", dat4, 32'h0);
        step();
        #3;
        chk("flush_drop", cnt4, 3'd0);

        // Branch slot: tag at 0x100, slot end at 0x108.
`ifdef PIPE_BRANCH_PC_EN
        exp31 = '{32'h100, 32'h100, 32'h100, 32'h10C};
`else
        exp31 = '{32'h100, 32'h104, 32'h108, 32'h10C};
`endif
        drive(1'b1, 32'h310, 32'h100, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h311, 32'h104, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h312, 32'h108, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h313, 32'h10C, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        out_ready_i = 1'b1;
        #3;
        chk("br_pc0", pc4, exp31[0]);
        for (int k = 1; k < 4; k++) begin
            step();
            #3;
            chk("br_pc", pc4, exp31[k]);
            chk("br_dat", dat4, DW'(32'h310 + k));
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // Tag and slot end together: tag wins, slot stays open.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, DW'(32'h320 + k), 32'h200, 1'b1, 1'b1);
            step();
            #3;
            chk("tagse_pc", pc4, 32'h200);
            chk("tagse_dat", dat4, DW'(32'h320 + k));
        end
        drive(1'b1, 32'h330, 32'h300, 1'b0, 1'b0);
        step();
        #3;
`ifdef PIPE_BRANCH_PC_EN
        chk("tagse_held", pc4, 32'h200);
`else
        chk("tagse_held", pc4, 32'h300);
`endif
        in_valid_i = 1'b0;
        step();

        // Asynchronous reset between edges with DEPTH=2 full.
        out_ready_i = 1'b0;
        drive(1'b1, 32'h41, 32'h70, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h42, 32'h74, 1'b0, 1'b0);
        step();
        in_valid_i = 1'b0;
        chk("arst_pre_cnt", cnt2, 2'd2);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_cnt", cnt2, 2'd0);
        chk("arst_vld", vld2, 1'b0);
        chk("arst_rdy", rdy2, 1'b1);
        chk("arst_dat", dat2, 32'h0);
        chk("arst_pc",  pc2,  32'h0);
        #1 rst_i = 1'b0;
        drive(1'b1, 32'h33, 32'h80, 1'b0, 1'b0);
        step();
        in_valid_i = 1'b0;
        #3;
        chk("post_rst_cnt", cnt2, 2'd1);
        chk("post_rst_dat", dat2, 32'h33);
        chk("post_rst_pc",  pc2,  32'h80);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
